// File: rtl/alu_result_fifo.sv
// alu_result_fifo: result buffer between the bitwise-operation stage and its
// consumer. The zero/negative/parity flags of each word are captured once, when
// the word is pushed, and stored with it. The head entry is presented on the
// output port whenever the FIFO is non-empty. There is no fall-through, so a
// word pushed into an empty FIFO appears on the next cycle.
//
// Parameters:
//   WIDTH  result word width (default 16)
//   DEPTH  number of entries; must be a power of two and at least 2 (default 4)
//
// Ports:
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   in_data      result word from the upstream stage
//   in_valid     in_data is valid this cycle
//   in_ready     FIFO can accept a word (count < DEPTH); depends on state only
//   out_data     head result word (0 when empty)
//   out_zero     head word is all zeros (0 when empty)
//   out_neg      head word MSB (0 when empty)
//   out_parity   stored XOR-reduction of head word (0 when empty or disabled)
//   out_valid    head entry is valid (count != 0)
//   out_ready    consumer accepts the head entry
//   count        number of stored entries
//
// Configuration:
//   ALU_RESULT_PARITY_EN  when defined, a parity bit is stored per entry and
//                         driven on out_parity; otherwise out_parity is tied 0.
module alu_result_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_parity,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] mem_zero;
    logic [DEPTH-1:0] mem_neg;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Handshake state is derived from the registered count only
    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage is not reset; empty-state outputs are masked below instead
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_zero[wr_ptr] <= (in_data == '0);
            mem_neg[wr_ptr]  <= in_data[WIDTH-1];
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry, forced to zero while empty
    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_zero = out_valid & mem_zero[rd_ptr];
    assign out_neg  = out_valid & mem_neg[rd_ptr];

`ifdef ALU_RESULT_PARITY_EN
    logic [DEPTH-1:0] mem_par;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_par[wr_ptr] <= ^in_data;
        end
    end

    assign out_parity = out_valid & mem_par[rd_ptr];
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             neg;
        logic             par;
    } entry_t;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_neg;
    logic             out_parity;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       count;

    entry_t sb_q[$];
    int     n_cmp;
    int     n_err;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_parity (out_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic entry_t make_entry(input logic [WIDTH-1:0] d);
        entry_t e;
        e.data = d;
        e.zero = (d == 16'h0000);
        e.neg  = d[15];
`ifdef ALU_RESULT_PARITY_EN
        e.par  = ^d;
`else
        e.par  = 1'b0;
`endif
        return e;
    endfunction

    // Compare all outputs against the scoreboard's view of the FIFO
    task automatic check_outputs();
        int sz;
        sz = sb_q.size();
        check("count",     32'(count),     32'(sz));
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("in_ready",  32'(in_ready),  32'(sz < DEPTH));
        if (sz != 0) begin
            check("out_data",   32'(out_data),   32'(sb_q[0].data));
            check("out_zero",   32'(out_zero),   32'(sb_q[0].zero));
            check("out_neg",    32'(out_neg),    32'(sb_q[0].neg));
            check("out_parity", 32'(out_parity), 32'(sb_q[0].par));
        end else begin
            check("empty_data",   32'(out_data),   32'h0);
            check("empty_flags",  32'({out_zero, out_neg, out_parity}), 32'h0);
        end
    endtask

    // One clock: check at the falling edge, drive, then update the scoreboard
    task automatic do_cycle(input logic iv, input logic [WIDTH-1:0] d, input logic orr);
        logic do_push;
        logic do_pop;
        check_outputs();
        in_valid  = iv;
        in_data   = d;
        out_ready = orr;
        do_push = iv && (sb_q.size() < DEPTH);
        do_pop  = orr && (sb_q.size() != 0);
        @(posedge clk);
        if (do_pop) void'(sb_q.pop_front());
        if (do_push) sb_q.push_back(make_entry(d));
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic [WIDTH-1:0] vec [4];
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single word into an empty FIFO appears the following cycle
        do_cycle(1'b1, 16'h00F0, 1'b0);
        do_cycle(1'b0, 16'h0000, 1'b1);
        do_cycle(1'b0, 16'h0000, 1'b0);

        // Fill with flag-corner words, try an overflow push, then full push+pop
        vec[0] = 16'h0000; vec[1] = 16'h8001; vec[2] = 16'h7FFF; vec[3] = 16'hFFFF;
        for (int i = 0; i < 4; i++) do_cycle(1'b1, vec[i], 1'b0);
        do_cycle(1'b1, 16'h1111, 1'b0);
        do_cycle(1'b1, 16'h2222, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 16'h0000, 1'b1);

        // Steady-state push+pop at count=2 across pointer wrap
        do_cycle(1'b1, 16'hA5A5, 1'b0);
        do_cycle(1'b1, 16'h5A5A, 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, 16'h1234 + 16'(i), 1'b1);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 16'h0000, 1'b1);

        // Parity-disabled style vector
        do_cycle(1'b1, 16'h0001, 1'b0);
        do_cycle(1'b0, 16'h0000, 1'b1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0:       rd = 16'h0000;
                1:       rd = 16'h8000;
                default: rd = 16'($urandom);
            endcase
            do_cycle(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 16'h0000, 1'b1);

        // Asynchronous reset between edges with three entries stored
        do_cycle(1'b1, 16'hDEAD, 1'b0);
        do_cycle(1'b1, 16'hBEEF, 1'b0);
        do_cycle(1'b1, 16'hCAFE, 1'b0);
        check("pre_rst_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        do_cycle(1'b1, 16'h0F0F, 1'b0);
        do_cycle(1'b1, 16'h3C3C, 1'b1);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 16'h0000, 1'b1);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of result words, matching the 16-bit bitwise-operation stage that feeds this block.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of buffered entries; it SHALL be a power of two, minimum 2.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous and active-high.
REQ-005 Port in_data  input  WIDTH: result word from the upstream operation stage.
REQ-006 Port in_valid  input  1: in_data is valid this cycle.
REQ-007 Port in_ready  output  1: FIFO can accept a word this cycle.
REQ-008 Port out_data  output  WIDTH: head-entry result word.
REQ-009 Port out_zero  output  1: head entry is all zeros.
REQ-010 Port out_neg  output  1: head entry MSB (bit WIDTH-1).
REQ-011 Port out_parity  output  1: even-parity bit of the head entry (see Configuration).
REQ-012 Port out_valid  output  1: head entry is valid.
REQ-013 Port out_ready  input  1: consumer accepts the head entry this cycle.
REQ-014 Port count  output  log2(DEPTH)+1: number of stored entries.

Function
REQ-015 A push SHALL occur on a clock edge when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be registered-state-derived only: 1 exactly when count < DEPTH; no combinational path from out_ready to in_ready.
REQ-017 Flags zero, neg and parity SHALL be computed from in_data at push and stored with the entry; they SHALL never be recomputed at the output.
REQ-018 Latency: a word pushed into an empty FIFO SHALL appear on out_data with out_valid=1 on the cycle after the push edge; no same-cycle fall-through.
REQ-019 out_valid SHALL equal (count != 0); out_data and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-021 When count = DEPTH, in_valid SHALL be ignored (in_ready=0); a pop on that cycle SHALL reduce count to DEPTH-1, with in_ready=1 the following cycle.
REQ-022 When count = 0, out_ready SHALL be ignored; a push on that cycle SHALL set count to 1.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap or duplicate.
REQ-024 When out_valid=0, out_data, out_zero, out_neg and out_parity SHALL be driven 0.

Reset
REQ-025 Asserting rst SHALL immediately, without waiting for clk, clear both pointers and count to 0, so out_valid=0, in_ready=1, and all data/flag outputs are 0.
REQ-026 Reset mid-operation SHALL discard all stored entries; no entry present before reset SHALL appear after reset.
REQ-027 Storage array contents need not be cleared; outputs SHALL be masked per REQ-024.

Configuration
REQ-028 Macro ALU_RESULT_PARITY_EN defined: each entry SHALL store XOR-reduction of in_data, and out_parity SHALL present it for the head entry.
REQ-029 Macro ALU_RESULT_PARITY_EN undefined: parity storage SHALL be omitted and out_parity SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-030 Reset then push 16'h00F0 -> next cycle out_valid=1, out_data=16'h00F0, out_zero=0, out_neg=0, count=1; parity=0 with macro.
REQ-031 Push 16'h0000, 16'h8001, 16'h7FFF, 16'hFFFF with out_ready=0 -> count=4, in_ready=0; fifth push ignored; pops in order give zero=1/neg=0, zero=0/neg=1, zero=0/neg=0, zero=0/neg=1; parity (macro) 0,0,1,0.
REQ-032 Full FIFO, in_valid=1 and out_ready=1 same cycle -> only pop occurs, count=3, in_ready=1 next cycle.
REQ-033 count=2, push 16'h1234 and pop same cycle for 10 consecutive cycles -> count stays 2, output order equals input order across pointer wrap.
REQ-034 count=3, assert rst asynchronously between edges -> out_valid=0, count=0, in_ready=1 before next edge; later pushes return only new data.
REQ-035 Build without ALU_RESULT_PARITY_EN, push 16'h0001 -> out_parity=0, out_data=16'h0001.
